// File: rtl/cpu_controller_if.sv
// Control bus between the multicycle sequencer and the 32-bit RISC datapath/RAM.
// The master side is the sequencer: it takes the decode and handshake inputs and drives the datapath strobes and status.
interface cpu_controller_if #(
  parameter int WIDTH = 32
);
  logic [5:0]       ir_op;
  logic             comp_in;
  logic             mem_ready;
  logic             run;
  logic             pcFetch;
  logic             pcEn;
  logic             pcIncSel;
  logic             pcAddSel;
  logic             pcRegSel;
  logic             irEn;
  logic             marEn;
  logic             ldEn;
  logic             stEn;
  logic             mdrEn;
  logic             wr;
  logic             wEn;
  logic             halted;
  logic             mem_err;
  logic [3:0]       state;
  logic [WIDTH-1:0] retired;

  modport master (
    input  ir_op, comp_in, mem_ready, run,
    output pcFetch, pcEn, pcIncSel, pcAddSel, pcRegSel, irEn, marEn,
           ldEn, stEn, mdrEn, wr, wEn, halted, mem_err, state, retired
  );

  modport slave (
    output ir_op, comp_in, mem_ready, run,
    input  pcFetch, pcEn, pcIncSel, pcAddSel, pcRegSel, irEn, marEn,
           ldEn, stEn, mdrEn, wr, wEn, halted, mem_err, state, retired
  );
endinterface

// File: rtl/cpu_controller.sv
// Multicycle fetch/decode/execute sequencer; 4-7 cycles per instruction with RAM ready, Moore strobes from state.
// Stalls in F_READ/LD_READ/ST_WRITE until mem_ready; a watchdog halts with mem_err after TIMEOUT idle cycles.
module cpu_controller #(
  parameter int WIDTH   = 32,
  parameter int TIMEOUT = 16
) (
  input logic            clk,
  input logic            reset,
  cpu_controller_if.master bus
);

  typedef enum logic [3:0] {
    IDLE     = 4'd0,
    F_ADDR   = 4'd1,
    F_READ   = 4'd2,
    PC_INC   = 4'd3,
    DECODE   = 4'd4,
    ALU_WB   = 4'd5,
    M_ADDR   = 4'd6,
    LD_READ  = 4'd7,
    LD_WB    = 4'd8,
    ST_LOAD  = 4'd9,
    ST_WRITE = 4'd10,
    BRANCH   = 4'd11,
    HALT     = 4'd12
  } stateT;

  localparam int WdW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  localparam logic [5:0] OP_JR   = 6'b110000;
  localparam logic [5:0] OP_BR   = 6'b110001;
  localparam logic [5:0] OP_BRC  = 6'b110010;
  localparam logic [5:0] OP_HALT = 6'b111111;

  stateT            curState;
  stateT            nextState;
  logic [WIDTH-1:0] retiredQ;
  logic             memErrQ;
  logic [WdW-1:0]   wdCnt;
  logic             waiting;
  logic             wdHit;
  logic             retire;
  logic             timeout;

  assign waiting = (curState == F_READ) || (curState == LD_READ) || (curState == ST_WRITE);
  // The limit cycle itself still accepts mem_ready; only a miss there faults.
  assign wdHit   = (wdCnt == WdW'(TIMEOUT - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      curState <= IDLE;
      retiredQ <= '0;
      memErrQ  <= 1'b0;
      wdCnt    <= '0;
    end else begin
      curState <= nextState;
      if (retire)  retiredQ <= retiredQ + 1'b1;
      if (timeout) memErrQ  <= 1'b1;
      if (!waiting)            wdCnt <= '0;
      else if (!bus.mem_ready) wdCnt <= wdCnt + 1'b1;
    end
  end

  always_comb begin
    nextState    = curState;
    retire       = 1'b0;
    timeout      = 1'b0;
    bus.pcFetch  = 1'b0;
    bus.pcEn     = 1'b0;
    bus.pcIncSel = 1'b0;
    bus.pcAddSel = 1'b0;
    bus.pcRegSel = 1'b0;
    bus.irEn     = 1'b0;
    bus.marEn    = 1'b0;
    bus.ldEn     = 1'b0;
    bus.stEn     = 1'b0;
    bus.mdrEn    = 1'b0;
    bus.wr       = 1'b0;
    bus.wEn      = 1'b0;
    bus.halted   = 1'b0;

    unique case (curState)
      IDLE: if (bus.run) nextState = F_ADDR;
      F_ADDR: begin
        bus.pcFetch = 1'b1;
        bus.marEn   = 1'b1;
        nextState   = F_READ;
      end
      F_READ: begin
        bus.irEn = 1'b1;
        if (bus.mem_ready) nextState = PC_INC;
        else if (wdHit) begin
          nextState = HALT;
          timeout   = 1'b1;
        end
      end
      PC_INC: begin
        bus.pcEn     = 1'b1;
        bus.pcIncSel = 1'b1;
        nextState    = DECODE;
      end
      DECODE: begin
        unique case (bus.ir_op[5:4])
          2'b00, 2'b01: nextState = ALU_WB;
          2'b10:        nextState = M_ADDR;
          default: begin
            if (bus.ir_op == OP_JR || bus.ir_op == OP_BR || bus.ir_op == OP_BRC)
              nextState = BRANCH;
            else if (bus.ir_op == OP_HALT)
              nextState = HALT;
            else begin
              nextState = F_ADDR;
              retire    = 1'b1;
            end
          end
        endcase
      end
      ALU_WB, LD_WB: begin
        bus.wEn   = 1'b1;
        nextState = F_ADDR;
        retire    = 1'b1;
      end
      M_ADDR: begin
        bus.marEn = 1'b1;
        nextState = bus.ir_op[0] ? ST_LOAD : LD_READ;
      end
      LD_READ: begin
        bus.ldEn  = 1'b1;
        bus.mdrEn = 1'b1;
        if (bus.mem_ready) nextState = LD_WB;
        else if (wdHit) begin
          nextState = HALT;
          timeout   = 1'b1;
        end
      end
      ST_LOAD: begin
        bus.stEn  = 1'b1;
        bus.mdrEn = 1'b1;
        nextState = ST_WRITE;
      end
      ST_WRITE: begin
        bus.wr = 1'b1;
        if (bus.mem_ready) begin
          nextState = F_ADDR;
          retire    = 1'b1;
        end else if (wdHit) begin
          nextState = HALT;
          timeout   = 1'b1;
        end
      end
      BRANCH: begin
        // pcIncSel=0 with pcRegSel=0 loads Ra; pcIncSel=1 with pcAddSel=1 adds the literal.
        if (bus.ir_op == OP_JR) begin
          bus.pcEn = 1'b1;
        end else if (bus.ir_op == OP_BR || (bus.ir_op == OP_BRC && bus.comp_in)) begin
          bus.pcEn     = 1'b1;
          bus.pcIncSel = 1'b1;
          bus.pcAddSel = 1'b1;
        end
        nextState = F_ADDR;
        retire    = 1'b1;
      end
      HALT:    bus.halted = 1'b1;
      default: nextState = IDLE;
    endcase
  end

  assign bus.state   = curState;
  assign bus.retired = retiredQ;
  assign bus.mem_err = memErrQ;

endmodule

// File: tb/tb_cpu_controller.sv
// Directed-vector bench for cpu_controller: walks each instruction class cycle by cycle against hand-derived states and strobes.
module tb_cpu_controller;

  logic clk = 1'b0;
  logic reset;
  int   tests = 0;
  int   fails = 0;

  // Strobe vector order: pcFetch pcEn pcIncSel pcAddSel pcRegSel irEn marEn ldEn stEn mdrEn wr wEn halted
  localparam logic [12:0] PCF = 13'h1000;
  localparam logic [12:0] PCE = 13'h0800;
  localparam logic [12:0] PCI = 13'h0400;
  localparam logic [12:0] PCA = 13'h0200;
  localparam logic [12:0] IRE = 13'h0080;
  localparam logic [12:0] MAR = 13'h0040;
  localparam logic [12:0] LDE = 13'h0020;
  localparam logic [12:0] STE = 13'h0010;
  localparam logic [12:0] MDR = 13'h0008;
  localparam logic [12:0] WR  = 13'h0004;
  localparam logic [12:0] WEN = 13'h0002;
  localparam logic [12:0] HLT = 13'h0001;

  cpu_controller_if #(.WIDTH(32)) ifc ();

  cpu_controller #(.WIDTH(32), .TIMEOUT(16)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (ifc)
  );

  always #5 clk = ~clk;

  function automatic logic [12:0] strobes();
    return {ifc.pcFetch, ifc.pcEn, ifc.pcIncSel, ifc.pcAddSel, ifc.pcRegSel, ifc.irEn,
            ifc.marEn, ifc.ldEn, ifc.stEn, ifc.mdrEn, ifc.wr, ifc.wEn, ifc.halted};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chkSt(input string tag, input logic [3:0] expState, input logic [12:0] expStb);
    chk({tag, "_state"}, 32'(ifc.state), 32'(expState));
    chk({tag, "_strobes"}, 32'(strobes()), 32'(expStb));
  endtask

  task automatic runFetch(input string tag);
    tick(); chkSt({tag, "_fread"}, 4'd2, IRE);
    tick(); chkSt({tag, "_pcinc"}, 4'd3, PCE | PCI);
    tick(); chkSt({tag, "_decode"}, 4'd4, 13'h0);
  endtask

  initial begin
    reset         = 1'b1;
    ifc.run       = 1'b0;
    ifc.ir_op     = 6'b000000;
    ifc.comp_in   = 1'b0;
    ifc.mem_ready = 1'b0;
    tick(); tick();
    chkSt("reset", 4'd0, 13'h0);
    chk("reset_retired", ifc.retired, 32'd0);
    chk("reset_memerr", 32'(ifc.mem_err), 32'd0);

    // ALU register op with RAM always ready
    reset = 1'b0; ifc.run = 1'b1; ifc.ir_op = 6'b000010; ifc.mem_ready = 1'b1;
    tick(); chkSt("alu_faddr", 4'd1, PCF | MAR);
    ifc.run = 1'b0;
    runFetch("alu");
    tick(); chkSt("alu_wb", 4'd5, WEN);
    chk("alu_retired_pre", ifc.retired, 32'd0);
    tick(); chkSt("alu_done", 4'd1, PCF | MAR);
    chk("alu_retired", ifc.retired, 32'd1);

    // Load with mem_ready low for three LD_READ cycles
    ifc.ir_op = 6'b100000;
    runFetch("ld");
    tick(); chkSt("ld_maddr", 4'd6, MAR);
    ifc.mem_ready = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      tick(); chkSt("ld_read", 4'd7, LDE | MDR);
      if (i == 4) ifc.mem_ready = 1'b1;
    end
    tick(); chkSt("ld_wb", 4'd8, WEN);
    tick(); chkSt("ld_done", 4'd1, PCF | MAR);
    chk("ld_retired", ifc.retired, 32'd2);

    // BRC not taken, then taken, then JR
    ifc.ir_op = 6'b110010; ifc.comp_in = 1'b0;
    runFetch("brc0");
    tick(); chkSt("brc0_branch", 4'd11, 13'h0);
    tick(); chk("brc0_retired", ifc.retired, 32'd3);
    ifc.comp_in = 1'b1;
    runFetch("brc1");
    tick(); chkSt("brc1_branch", 4'd11, PCE | PCI | PCA);
    tick(); chkSt("brc1_done", 4'd1, PCF | MAR);
    chk("brc1_retired", ifc.retired, 32'd4);
    ifc.comp_in = 1'b0;
    ifc.ir_op = 6'b110000;
    runFetch("jr");
    tick(); chkSt("jr_branch", 4'd11, PCE);
    tick(); chk("jr_retired", ifc.retired, 32'd5);

    // Async reset while a store is driving RAM
    ifc.ir_op = 6'b100001;
    runFetch("strst");
    tick(); chkSt("strst_maddr", 4'd6, MAR);
    tick(); chkSt("strst_stload", 4'd9, STE | MDR);
    ifc.mem_ready = 1'b0;
    tick(); chkSt("strst_write", 4'd10, WR);
    reset = 1'b1;
    #1;
    chk("strst_wr_drop", 32'(ifc.wr), 32'd0);
    chkSt("strst_reset", 4'd0, 13'h0);
    chk("strst_retired", ifc.retired, 32'd0);
    chk("strst_memerr", 32'(ifc.mem_err), 32'd0);
    tick();
    reset = 1'b0;
    tick(); chkSt("idle_hold", 4'd0, 13'h0);

    // NOP, ALU, BR, then HALT
    ifc.run = 1'b1; ifc.ir_op = 6'b110111; ifc.mem_ready = 1'b1;
    tick(); chkSt("nop_faddr", 4'd1, PCF | MAR);
    ifc.run = 1'b0;
    runFetch("nop");
    tick(); chkSt("nop_done", 4'd1, PCF | MAR);
    chk("nop_retired", ifc.retired, 32'd1);
    ifc.ir_op = 6'b000101;
    runFetch("alu2");
    tick(); chkSt("alu2_wb", 4'd5, WEN);
    tick(); chk("alu2_retired", ifc.retired, 32'd2);
    ifc.ir_op = 6'b110001;
    runFetch("br");
    tick(); chkSt("br_branch", 4'd11, PCE | PCI | PCA);
    tick(); chk("br_retired", ifc.retired, 32'd3);
    ifc.ir_op = 6'b111111;
    runFetch("halt");
    tick(); chkSt("halt_enter", 4'd12, HLT);
    chk("halt_retired", ifc.retired, 32'd3);
    chk("halt_memerr", 32'(ifc.mem_err), 32'd0);
    ifc.run = 1'b1; tick();
    ifc.run = 1'b0; tick();
    ifc.run = 1'b1; tick();
    chkSt("halt_stay", 4'd12, HLT);
    chk("halt_retired_stay", ifc.retired, 32'd3);
    ifc.run = 1'b0;

    // Store with mem_ready arriving exactly on the limit cycle, then a store that times out
    reset = 1'b1; tick();
    reset = 1'b0; ifc.run = 1'b1; ifc.ir_op = 6'b100001; ifc.mem_ready = 1'b1;
    tick(); chkSt("stlim_faddr", 4'd1, PCF | MAR);
    ifc.run = 1'b0;
    runFetch("stlim");
    tick(); chkSt("stlim_maddr", 4'd6, MAR);
    tick(); chkSt("stlim_stload", 4'd9, STE | MDR);
    ifc.mem_ready = 1'b0;
    for (int i = 1; i <= 16; i++) begin
      tick(); chkSt("stlim_write", 4'd10, WR);
      if (i == 16) ifc.mem_ready = 1'b1;
    end
    tick(); chkSt("stlim_done", 4'd1, PCF | MAR);
    chk("stlim_retired", ifc.retired, 32'd1);
    chk("stlim_memerr", 32'(ifc.mem_err), 32'd0);

    runFetch("stto");
    tick(); chkSt("stto_maddr", 4'd6, MAR);
    tick(); chkSt("stto_stload", 4'd9, STE | MDR);
    ifc.mem_ready = 1'b0;
    for (int i = 1; i <= 16; i++) begin
      tick(); chkSt("stto_write", 4'd10, WR);
    end
    tick(); chkSt("stto_halt", 4'd12, HLT);
    chk("stto_memerr", 32'(ifc.mem_err), 32'd1);
    chk("stto_retired", ifc.retired, 32'd1);
    tick(); chk("stto_memerr_sticky", 32'(ifc.mem_err), 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/cpu_controller.md
Name: cpu_controller

Overview:
- Multicycle sequencer for the 32-bit RISC datapath.
- Decodes the instruction register opcode and the comparator flag.
- Drives every datapath control strobe (PC, IR, MAR, MDR, load/store buffers, RAM write, register-file write) through fetch, decode and execute states.
- Handshakes with RAM through mem_ready, with a timeout watchdog, and counts retired instructions.

Parameters:
WIDTH, 32, width of the retired-instruction counter
TIMEOUT, 16, max cycles to wait for mem_ready before faulting (>=1)

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high reset
ir_op  input  6  instruction register bits [31:26]
comp_in  input  1  comparator flag from datapath
mem_ready  input  1  RAM read data valid / write accepted
run  input  1  start request, sampled only in IDLE
pcFetch  output  1  1: MAR source is PC; 0: MAR source is Ra
pcEn  output  1  PC load enable
pcIncSel  output  1  1: PC adds (pcAddSel); 0: PC loads pcIn; also register-file source select (0 = ALU/MDR)
pcAddSel  output  1  0: +4; 1: +sign-extended literal
pcRegSel  output  1  PC input mux: 0 = Ra, 1 = Rc
irEn  output  1  IR load enable
marEn  output  1  MAR load enable
ldEn  output  1  RAM-to-MDR buffer enable
stEn  output  1  Rc-to-MDR buffer enable
mdrEn  output  1  MDR load enable
wr  output  1  MDR-to-RAM drive / RAM write
wEn  output  1  register-file write enable
halted  output  1  in HALT state
mem_err  output  1  sticky memory-timeout fault
state  output  4  current state encoding (debug)
retired  output  WIDTH  retired-instruction count

Behaviour:
Outputs and state:
- All control outputs are Moore outputs decoded from state only; each is 0 unless listed for a state.
- Reset (async) -> IDLE; retired=0, mem_err=0, all strobes 0. Reset mid-instruction aborts immediately; no partial write completes after reset asserts.

Opcode classes (ir_op[5:4]):
- 00 = ALU register op.
- 01 = ALU immediate op.
- 10 = memory op: ir_op[0]=0 load, 1 store.
- 11 = control:
  - 110000 JR (PC<=Ra)
  - 110001 BR (PC<=PC+ext)
  - 110010 BRC (branch if comp_in)
  - 111111 HALT
  - all other 11xxxx = NOP.

States (encoding, asserted outputs, transition):
- 0 IDLE: -> F_ADDR when run=1.
- 1 F_ADDR: pcFetch, marEn. -> F_READ.
- 2 F_READ: irEn every cycle. -> PC_INC when mem_ready.
- 3 PC_INC: pcEn, pcIncSel, pcAddSel=0. -> DECODE.
- 4 DECODE: no strobes; branches on ir_op:
  - ALU -> ALU_WB
  - memory -> M_ADDR
  - JR/BR/BRC -> BRANCH
  - HALT -> HALT
  - NOP -> F_ADDR (retires)
- 5 ALU_WB: wEn, pcIncSel=0. -> F_ADDR (retires).
- 6 M_ADDR: marEn, pcFetch=0. -> LD_READ if load, ST_LOAD if store.
- 7 LD_READ: ldEn, mdrEn every cycle. -> LD_WB when mem_ready.
- 8 LD_WB: wEn, pcIncSel=0. -> F_ADDR (retires).
- 9 ST_LOAD: stEn, mdrEn. -> ST_WRITE.
- 10 ST_WRITE: wr held. -> F_ADDR when mem_ready (retires).
- 11 BRANCH:
  - JR: pcEn, pcIncSel=0, pcRegSel=0.
  - BR: pcEn, pcIncSel=1, pcAddSel=1.
  - BRC: same as BR when comp_in=1; when comp_in=0 all strobes 0.
  - -> F_ADDR (retires).
- 12 HALT: halted=1. Stays until reset; run ignored.

Branch semantics:
- Relative branch target = PC+4+ext, because PC_INC precedes it.
- comp_in is sampled in BRANCH only.

Retirement:
- retired increments by 1 on each edge leaving a retiring state, wrapping modulo 2^WIDTH.
- HALT is not counted.

Watchdog:
- Counter clears on entry to F_READ, LD_READ or ST_WRITE and increments each cycle there with mem_ready=0.
- If TIMEOUT cycles elapse without mem_ready -> HALT with mem_err=1. mem_err clears only on reset.
- mem_ready on the same cycle the limit is reached counts as success.

Timing:
- Latency with mem_ready held high: ALU/NOP-free instruction 5 cycles (F_ADDR, F_READ, PC_INC, DECODE, ALU_WB); load 7; store 7; branch 5; NOP 4.

Test Plan:
1. Reset asserted in ST_WRITE with wr=1 -> wr drops same cycle (async); state=0, retired=0, mem_err=0.
2. run=1, ALU op 000010, mem_ready=1 -> states 1,2,3,4,5,1; wEn=1 exactly one cycle; retired=1 after 5 cycles.
3. Load 100000, mem_ready low 3 cycles in LD_READ -> ldEn/mdrEn held 4 cycles; wEn one cycle in LD_WB; total 10 cycles.
4. BRC with comp_in=0 then comp_in=1 -> first BRANCH pcEn=0, second pcEn=1 with pcAddSel=1; retired advances by 2.
5. Store 100001, mem_ready never asserted, TIMEOUT=16 -> wr high 16 cycles, then state=12, halted=1, mem_err=1, retired unchanged.
6. HALT 111111 after 3 instructions -> halted=1, retired=3; run pulses ignored; NOP 110111 earlier returns to F_ADDR in 4 cycles.
